// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage MIPS-style pipeline: load-use stalls, branch/jump
// flushes, data-memory wait freeze, EX/MEM forwarding select and event counters.
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ifid_ir,
   input  logic [4:0]  dx_rd,
   input  logic        dx_memread,
   input  logic        dx_regwrite,
   input  logic [4:0]  xm_rd,
   input  logic        xm_regwrite,
   input  logic        br_taken,
   input  logic        dx_jump,
   input  logic        mem_busy,
   output logic        pipe_en,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   // state   | meaning
   // RUN     | no hazard last cycle, pipeline advancing
   // LDSTALL | bubble inserted behind a lw, IF/ID and PC held
   // FLUSH   | IF/ID holds a nop after a taken branch or jump
   // MWAIT   | data memory busy, whole pipeline frozen
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2,
      MWAIT   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic        uses_rs, uses_rt;
   logic        load_use, redirect;
   logic        stall_evt, flush_evt;
   logic        unused_inputs;

   assign opcode = ifid_ir[31:26];
   assign rs     = ifid_ir[25:21];
   assign rt     = ifid_ir[20:16];

   // Immediate/funct bits and the ID/EX write enable are not needed for hazard detection
   assign unused_inputs = ^{dx_regwrite, ifid_ir[15:0]};

   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         6'd0:  begin uses_rs = 1'b1; uses_rt = 1'b1; end
         6'd35: begin uses_rs = 1'b1; uses_rt = 1'b0; end
         6'd43: begin uses_rs = 1'b1; uses_rt = 1'b1; end
         6'd4:  begin uses_rs = 1'b1; uses_rt = 1'b1; end
         6'd5:  begin uses_rs = 1'b1; uses_rt = 1'b1; end
         default: begin uses_rs = 1'b0; uses_rt = 1'b0; end
      endcase
   end

   assign load_use = dx_memread && (dx_rd != 5'd0) &&
                     ((uses_rs && (dx_rd == rs)) || (uses_rt && (dx_rd == rt)));
   assign redirect = br_taken | dx_jump;

   // The nop sitting in IF/ID during FLUSH cannot be a load-use consumer
   assign flush_evt = !mem_busy && redirect;
   assign stall_evt = !mem_busy && !redirect && load_use && (state_q != FLUSH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= RUN;
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         state_q <= state_d;
         if (stall_evt && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (flush_evt && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   always_comb begin
      state_d = RUN;
      if (mem_busy)
         state_d = MWAIT;
      else if (redirect)
         state_d = FLUSH;
      else if (stall_evt)
         state_d = LDSTALL;
   end

   always_comb begin
      pipe_en     = 1'b1;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
      if (rst) begin
         if (mem_busy) begin
            pipe_en    = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (stall_evt) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         if (xm_regwrite && (xm_rd != 5'd0) && uses_rs && (xm_rd == rs))
            fwd_a = 2'd1;
         if (xm_regwrite && (xm_rd != 5'd0) && uses_rt && (xm_rd == rt))
            fwd_b = 2'd1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each task drives one scenario and checks
// combinational controls and registered state/counters against hand-derived values.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifid_ir;
   logic [4:0]  dx_rd;
   logic        dx_memread;
   logic        dx_regwrite;
   logic [4:0]  xm_rd;
   logic        xm_regwrite;
   logic        br_taken;
   logic        dx_jump;
   logic        mem_busy;
   logic        pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [15:0] stall_cnt, flush_cnt;

   int passed = 0;
   int total  = 0;

   localparam logic [31:0] ADD_3_2_1 = {6'd0, 5'd2, 5'd1, 5'd3, 5'd0, 6'd32};
   localparam logic [31:0] SUB_6_5_5 = {6'd0, 5'd5, 5'd5, 5'd6, 5'd0, 6'd34};
   localparam logic [31:0] J_RT9     = {6'd2, 5'd7, 5'd9, 16'h0010};
   localparam logic [31:0] ADD_0_0_0 = {6'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'd32};
   localparam logic [31:0] LW_RT2    = {6'd35, 5'd8, 5'd2, 16'h0004};

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst), .ifid_ir(ifid_ir), .dx_rd(dx_rd),
      .dx_memread(dx_memread), .dx_regwrite(dx_regwrite),
      .xm_rd(xm_rd), .xm_regwrite(xm_regwrite), .br_taken(br_taken),
      .dx_jump(dx_jump), .mem_busy(mem_busy), .pipe_en(pipe_en),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifid_ir = 32'd0; dx_rd = 5'd0; dx_memread = 1'b0; dx_regwrite = 1'b0;
      xm_rd = 5'd0; xm_regwrite = 1'b0; br_taken = 1'b0; dx_jump = 1'b0;
      mem_busy = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd2; dx_memread = 1'b1; mem_busy = 1'b1;
      xm_rd = 5'd2; xm_regwrite = 1'b1;
      rst = 1'b0;
      #1;
      total++; if ({pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush} !== 5'b11100)
         $display("FAIL rst_ctrl got %b exp 11100", {pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush}); else passed++;
      total++; if ({fwd_a, fwd_b} !== 4'b0000)
         $display("FAIL rst_fwd got %b exp 0000", {fwd_a, fwd_b}); else passed++;
      tick(); tick();
      total++; if ({state, stall_cnt, flush_cnt} !== {2'd0, 16'd0, 16'd0})
         $display("FAIL rst_regs state %0d stall %0d flush %0d exp 0 0 0", state, stall_cnt, flush_cnt); else passed++;
      idle_inputs();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd2; dx_memread = 1'b1; dx_regwrite = 1'b1;
      #1;
      total++; if ({pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en} !== 5'b00101)
         $display("FAIL ld_ctrl got %b exp 00101", {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en}); else passed++;
      tick();
      total++; if (state !== 2'd1 || stall_cnt !== 16'd1)
         $display("FAIL ld_state state %0d stall %0d exp 1 1", state, stall_cnt); else passed++;
      dx_memread = 1'b0;
      #1;
      total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         $display("FAIL ld_release pc_write %b bubble %b exp 1 0", pc_write, idex_bubble); else passed++;
      tick();
      total++; if (state !== 2'd0 || stall_cnt !== 16'd1)
         $display("FAIL ld_exit state %0d stall %0d exp 0 1", state, stall_cnt); else passed++;
      // lw reading only rs: rt match alone must not stall
      ifid_ir = LW_RT2; dx_rd = 5'd2; dx_memread = 1'b1;
      #1;
      total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         $display("FAIL lw_rt_nostall pc_write %b bubble %b exp 1 0", pc_write, idex_bubble); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_redirect_priority();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd2; dx_memread = 1'b1; br_taken = 1'b1;
      #1;
      total++; if ({ifid_flush, pc_write, idex_bubble, pipe_en} !== 4'b1111)
         $display("FAIL br_ctrl got %b exp 1111", {ifid_flush, pc_write, idex_bubble, pipe_en}); else passed++;
      tick();
      total++; if (state !== 2'd2 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1)
         $display("FAIL br_state state %0d flush %0d stall %0d exp 2 1 1", state, flush_cnt, stall_cnt); else passed++;
      br_taken = 1'b0;
      #1;
      total++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100)
         $display("FAIL flush_ignores_ld got %b exp 1100", {pc_write, ifid_write, idex_bubble, ifid_flush}); else passed++;
      tick();
      total++; if (state !== 2'd0 || stall_cnt !== 16'd1)
         $display("FAIL flush_exit state %0d stall %0d exp 0 1", state, stall_cnt); else passed++;
      dx_jump = 1'b1;
      tick();
      total++; if (state !== 2'd2 || flush_cnt !== 16'd2)
         $display("FAIL jump_flush state %0d flush %0d exp 2 2", state, flush_cnt); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_mem_busy();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd2; dx_memread = 1'b1; mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush} !== 5'b00000)
            $display("FAIL mw_ctrl cyc %0d got %b exp 00000", i, {pipe_en, pc_write, ifid_write, idex_bubble, ifid_flush}); else passed++;
         tick();
         total++; if (state !== 2'd3 || stall_cnt !== 16'd1 || flush_cnt !== 16'd2)
            $display("FAIL mw_state cyc %0d state %0d stall %0d flush %0d exp 3 1 2", i, state, stall_cnt, flush_cnt); else passed++;
      end
      mem_busy = 1'b0;
      #1;
      total++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || pipe_en !== 1'b1)
         $display("FAIL mw_exit_ctrl pc_write %b bubble %b pipe_en %b exp 0 1 1", pc_write, idex_bubble, pipe_en); else passed++;
      tick();
      total++; if (state !== 2'd1 || stall_cnt !== 16'd2)
         $display("FAIL mw_exit_state state %0d stall %0d exp 1 2", state, stall_cnt); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_forwarding();
      ifid_ir = SUB_6_5_5; xm_rd = 5'd5; xm_regwrite = 1'b1;
      #1;
      total++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1)
         $display("FAIL fwd_both a %0d b %0d exp 1 1", fwd_a, fwd_b); else passed++;
      xm_regwrite = 1'b0;
      #1;
      total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0)
         $display("FAIL fwd_nowrite a %0d b %0d exp 0 0", fwd_a, fwd_b); else passed++;
      ifid_ir = ADD_3_2_1; xm_rd = 5'd1; xm_regwrite = 1'b1;
      #1;
      total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd1)
         $display("FAIL fwd_rt_only a %0d b %0d exp 0 1", fwd_a, fwd_b); else passed++;
      ifid_ir = ADD_0_0_0; xm_rd = 5'd0;
      #1;
      total++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0)
         $display("FAIL fwd_r0 a %0d b %0d exp 0 0", fwd_a, fwd_b); else passed++;
      dx_rd = 5'd0; dx_memread = 1'b1;
      #1;
      total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         $display("FAIL r0_nostall pc_write %b bubble %b exp 1 0", pc_write, idex_bubble); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_jump_no_stall();
      ifid_ir = J_RT9; dx_rd = 5'd9; dx_memread = 1'b1; xm_rd = 5'd7; xm_regwrite = 1'b1;
      #1;
      total++; if ({pc_write, ifid_write, idex_bubble, fwd_a, fwd_b} !== 7'b1100000)
         $display("FAIL j_nostall got %b exp 1100000", {pc_write, ifid_write, idex_bubble, fwd_a, fwd_b}); else passed++;
      tick();
      total++; if (state !== 2'd0 || stall_cnt !== 16'd2)
         $display("FAIL j_state state %0d stall %0d exp 0 2", state, stall_cnt); else passed++;
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd1; dx_memread = 1'b1;
      tick();
      dx_rd = 5'd2;
      #1;
      total++; if (state !== 2'd1 || pc_write !== 1'b0 || idex_bubble !== 1'b1)
         $display("FAIL b2b_ctrl state %0d pc_write %b bubble %b exp 1 0 1", state, pc_write, idex_bubble); else passed++;
      tick();
      total++; if (state !== 2'd1 || stall_cnt !== 16'd4)
         $display("FAIL b2b_state state %0d stall %0d exp 1 4", state, stall_cnt); else passed++;
      idle_inputs();
      tick();
   endtask

   task automatic test_saturation_and_reset();
      ifid_ir = ADD_3_2_1; dx_rd = 5'd2; dx_memread = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      total++; if (stall_cnt !== 16'hFFFF || state !== 2'd1)
         $display("FAIL sat_reach stall %h state %0d exp FFFF 1", stall_cnt, state); else passed++;
      tick(); tick();
      total++; if (stall_cnt !== 16'hFFFF)
         $display("FAIL sat_hold stall %h exp FFFF", stall_cnt); else passed++;
      rst = 1'b0;
      #1;
      total++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
         $display("FAIL rst_mid_stall pc_write %b bubble %b exp 1 0", pc_write, idex_bubble); else passed++;
      tick();
      total++; if ({state, stall_cnt, flush_cnt} !== {2'd0, 16'd0, 16'd0})
         $display("FAIL rst_clear state %0d stall %h flush %h exp 0 0 0", state, stall_cnt, flush_cnt); else passed++;
      rst = 1'b1;
      idle_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_redirect_priority();
      test_mem_busy();
      test_forwarding();
      test_jump_no_stall();
      test_back_to_back();
      test_saturation_and_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
